rgb_breath_pwm: RTL and testbench
=================================

RGB_BREATH_PWM -- requirements
Module: rgb_breath_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 47: clk cycles per PWM tick, minimum 1.
REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter width. MAX = 2^PWM_BITS-1.
REQ-003 SHALL have parameter STEP_PERIODS, default 4: full PWM periods per duty step, minimum 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1: count enable. Low freezes all timing.
REQ-007 SHALL have port pwm, output, 1: registered breathing PWM wave, active-high duty.
REQ-008 SHALL have port state, output, 2: colour phase index 0/1/2, consumed by the downstream RGB mixer.
REQ-009 SHALL have port phase_done, output, 1: one-cycle pulse at each colour-phase change.

Function
REQ-010 SHALL contain a prescaler pre_cnt counting 0..PRESCALE-1 while en=1; tick = en && pre_cnt==PRESCALE-1; wraps to 0 on tick.
REQ-011 SHALL contain a PWM counter pwm_cnt (PWM_BITS wide) that increments on tick and wraps MAX->0; period_end = tick && pwm_cnt==MAX.
REQ-012 SHALL contain a repeat counter rep_cnt counting period_end events 0..STEP_PERIODS-1; step = period_end && rep_cnt==STEP_PERIODS-1; rep_cnt wraps to 0 on step.
REQ-013 SHALL hold a duty register (PWM_BITS wide) and a direction flag dir with two states, UP and DOWN.
REQ-014 In UP, on step: if duty==MAX, dir<=DOWN and duty<=MAX-1; otherwise duty<=duty+1.
REQ-015 In DOWN, on step: if duty==1, duty<=0, dir<=UP, state advances, and phase_done<=1; otherwise duty<=duty-1.
REQ-016 Per-phase duty sequence: 0,1,...,MAX,MAX-1,...,1; the next phase begins at 0. One phase lasts 2*MAX steps.
REQ-017 state SHALL advance 0->1->2->0. Value 3 is unreachable; if present, the next advance SHALL go to 0.
REQ-018 phase_done SHALL be high for exactly one clk, in the same cycle that state shows its new value; otherwise 0.
REQ-019 pwm SHALL register (pwm_cnt < duty) every clk while en=1, giving one-cycle latency.
REQ-020 duty==0 gives pwm constantly 0; duty==MAX gives pwm high for MAX of 2^PWM_BITS ticks.
REQ-021 A duty change SHALL occur only at period_end, so no period carries a mixed duty.
REQ-022 While en=0: pre_cnt, pwm_cnt, rep_cnt, duty, dir and state hold; pwm is driven 0; phase_done is 0.
REQ-023 When en returns to 1, counting SHALL resume from the held values with no lost or extra ticks.
REQ-024 Counter widths SHALL be sized from the parameters, with no truncation at the MAX or PRESCALE-1 boundaries.

Reset
REQ-025 When rst==0 at a rising clk edge, the following SHALL be loaded:
- pre_cnt=0, pwm_cnt=0, rep_cnt=0
- duty=0, dir=UP
- state=0, pwm=0, phase_done=0
REQ-026 Reset SHALL take priority over en and over any pending step or phase change.
REQ-027 Reset asserted mid-operation SHALL abort the current phase with no phase_done pulse.
REQ-028 After rst returns high, the timeline SHALL restart exactly as from power-up.

Verification (PRESCALE=2, PWM_BITS=2 so MAX=3, STEP_PERIODS=1: period=8 clk, phase=48 enabled clk)
REQ-029 Reset check:
- Stimulus: rst=0 for 3 clk, en=1.
- Response: pwm=0, state=0, phase_done=0 throughout.
REQ-030 Ramp check:
- Stimulus: release reset, en=1.
- Response, period 1 (duty 0): pwm 0 for all 8 clk.
- Response, period 2 (duty 1): pwm high 2 clk.
- Response, period 4 (duty 3): pwm high 6 of 8 clk.
REQ-031 Phase sequence check:
- Stimulus: free run with en=1.
- Response: phase_done pulses at enabled clk 48, 96 and 144 after reset release.
- Response: state goes 0->1->2->0, and never 3.
REQ-032 Enable check:
- Stimulus: en=0 for 10 clk inside phase 0.
- Response: pwm=0 during the gap.
- Response: the first phase_done arrives exactly 10 clk late.
REQ-033 Mid-operation reset check:
- Stimulus: rst=0 for 1 clk while state=2 and duty=2.
- Response: next cycle state=0, pwm=0, no phase_done.
- Response: the first phase_done arrives 48 clk after release.

Source files
------------

// File: rtl/rgb_breath_pwm.sv
// rgb_breath_pwm
//   Breathing PWM generator that sweeps one colour channel's duty up
//   from 0 to MAX and back down to 1, then hands over to the next colour
//   phase (0 -> 1 -> 2 -> 0).
//
//   Timing chain:
//     prescaler (PRESCALE clk per tick)
//       -> PWM counter (2^PWM_BITS ticks per period)
//       -> repeat counter (STEP_PERIODS periods per duty step)
//       -> duty/direction sweep (2*MAX steps per colour phase)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active low
//   en         : count enable; low freezes all timing and forces pwm low
//   pwm        : registered PWM output, high while pwm_cnt < duty
//   state      : colour phase index 0/1/2 for the downstream RGB mixer
//   phase_done : one-clk pulse, coincident with state taking its new value
//
// Sweep FSM (dir)
//   state | meaning
//   UP    | duty increments each step until it reaches MAX
//   DOWN  | duty decrements each step; at 1 -> 0 the colour phase advances

module rgb_breath_pwm #(
    parameter int PRESCALE     = 47,
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pwm,
    output logic [1:0] state,
    output logic       phase_done
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int REP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [REP_W-1:0]    REP_LAST = REP_W'(STEP_PERIODS - 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [REP_W-1:0]    rep_cnt;
    logic [PWM_BITS-1:0] duty;
    dir_t                dir;

    logic tick;
    logic period_end;
    logic step;

    assign tick       = en && (pre_cnt == PRE_LAST);
    assign period_end = tick && (pwm_cnt == MAX);
    assign step       = period_end && (rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            rep_cnt    <= '0;
            duty       <= '0;
            dir        <= UP;
            state      <= 2'd0;
            pwm        <= 1'b0;
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (en) begin
                // compare uses the pre-edge counter and duty: one clk latency
                pwm <= (pwm_cnt < duty);

                if (tick) begin
                    pre_cnt <= '0;
                    pwm_cnt <= pwm_cnt + DUTY_ONE;   // wraps MAX -> 0
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end

                if (period_end) begin
                    if (step) begin
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end

                // duty only ever moves on a period boundary
                if (step) begin
                    case (dir)
                        UP: begin
                            if (duty == MAX) begin
                                dir  <= DOWN;
                                duty <= MAX - DUTY_ONE;
                            end else begin
                                duty <= duty + DUTY_ONE;
                            end
                        end
                        DOWN: begin
                            if (duty == DUTY_ONE) begin
                                duty       <= '0;
                                dir        <= UP;
                                phase_done <= 1'b1;
                                // 3 is never produced but must recover to 0
                                if (state >= 2'd2) begin
                                    state <= 2'd0;
                                end else begin
                                    state <= state + 2'd1;
                                end
                            end else begin
                                duty <= duty - DUTY_ONE;
                            end
                        end
                        default: dir <= UP;
                    endcase
                end
            end else begin
                pwm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// Testbench for rgb_breath_pwm with PRESCALE=2, PWM_BITS=2, STEP_PERIODS=1.
// The reference model derives everything from the number of enabled clocks
// since reset release: ticks, PWM position, step count, duty in the
// triangular sweep and the colour phase are all plain arithmetic on it.

module tb_rgb_breath_pwm;

    localparam int P     = 2;
    localparam int B     = 2;
    localparam int SP    = 1;
    localparam int NSTEP = 1 << B;
    localparam int MAXV  = NSTEP - 1;
    localparam int PER   = P * NSTEP;
    localparam int PH    = PER * SP * 2 * MAXV;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pwm;
    logic [1:0] state;
    logic       phase_done;

    int assertions;
    int failures;
    int n_en;

    logic       ep;
    logic [1:0] es;
    logic       epd;

    rgb_breath_pwm #(
        .PRESCALE    (P),
        .PWM_BITS    (B),
        .STEP_PERIODS(SP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm       (pwm),
        .state     (state),
        .phase_done(phase_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_pwm_cnt(input int n);
        return (n / P) % NSTEP;
    endfunction

    function automatic int m_duty(input int n);
        int s;
        int q;
        s = n / (PER * SP);
        q = s % (2 * MAXV);
        return (q <= MAXV) ? q : (2 * MAXV - q);
    endfunction

    function automatic int m_state(input int n);
        return (n / PH) % 3;
    endfunction

    // Applies one clock of stimulus and returns the model's view of the
    // outputs just after that edge.
    task automatic drive_cycle(input logic en_v, input logic rst_v,
                               output logic e_pwm, output logic [1:0] e_state,
                               output logic e_pd);
        en  = en_v;
        rst = rst_v;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            n_en    = 0;
            e_pwm   = 1'b0;
            e_state = 2'd0;
            e_pd    = 1'b0;
        end else begin
            e_pwm = en_v && (m_pwm_cnt(n_en) < m_duty(n_en));
            if (en_v) n_en++;
            e_state = 2'(m_state(n_en));
            e_pd    = en_v && (n_en % PH == 0);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, ep, es, epd);
            assertions++;
            if (pwm !== ep) begin
                failures++;
                $display("FAIL reset_pwm cycle %0d: got %b want %b", k, pwm, ep);
            end
            assertions++;
            if (state !== es) begin
                failures++;
                $display("FAIL reset_state cycle %0d: got %0d want %0d", k, state, es);
            end
            assertions++;
            if (phase_done !== epd) begin
                failures++;
                $display("FAIL reset_phase_done cycle %0d: got %b want %b", k, phase_done, epd);
            end
        end
    endtask

    task automatic test_ramp;
        int hi[4];
        int want_hi[4];
        want_hi = '{0, 2, 4, 6};
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int k = 0; k < 32; k++) begin
            drive_cycle(1'b1, 1'b1, ep, es, epd);
            assertions++;
            if (pwm !== ep) begin
                failures++;
                $display("FAIL ramp_pwm cycle %0d: got %b want %b", k + 1, pwm, ep);
            end
            if (pwm === 1'b1) hi[k / 8]++;
        end
        for (int i = 0; i < 4; i++) begin
            assertions++;
            if (hi[i] != want_hi[i]) begin
                failures++;
                $display("FAIL ramp_high_count period %0d: got %0d want %0d", i + 1, hi[i], want_hi[i]);
            end
        end
    endtask

    task automatic test_phase_seq;
        int pd_at[$];
        logic [1:0] st_at[$];
        int want_at[3];
        logic [1:0] want_st[3];
        want_at = '{48, 96, 144};
        want_st = '{2'd1, 2'd2, 2'd0};
        drive_cycle(1'b1, 1'b0, ep, es, epd);
        for (int k = 1; k <= 150; k++) begin
            drive_cycle(1'b1, 1'b1, ep, es, epd);
            assertions++;
            if (state !== es || phase_done !== epd || pwm !== ep) begin
                failures++;
                $display("FAIL phase_seq_outputs cycle %0d: got st=%0d pd=%b pwm=%b want st=%0d pd=%b pwm=%b",
                         k, state, phase_done, pwm, es, epd, ep);
            end
            if (state === 2'd3) begin
                failures++;
                $display("FAIL phase_seq_state3 cycle %0d: got 3 want 0..2", k);
            end
            if (phase_done === 1'b1) begin
                pd_at.push_back(k);
                st_at.push_back(state);
            end
        end
        assertions++;
        if (pd_at.size() != 3) begin
            failures++;
            $display("FAIL phase_seq_pulse_count: got %0d want 3", pd_at.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                assertions++;
                if (pd_at[i] != want_at[i] || st_at[i] !== want_st[i]) begin
                    failures++;
                    $display("FAIL phase_seq_pulse %0d: got clk %0d state %0d want clk %0d state %0d",
                             i, pd_at[i], st_at[i], want_at[i], want_st[i]);
                end
            end
        end
    endtask

    task automatic test_enable;
        int first_pd;
        int k;
        first_pd = -1;
        drive_cycle(1'b1, 1'b0, ep, es, epd);
        for (k = 1; k <= 90; k++) begin
            drive_cycle((k > 20 && k <= 30) ? 1'b0 : 1'b1, 1'b1, ep, es, epd);
            assertions++;
            if (pwm !== ep || state !== es || phase_done !== epd) begin
                failures++;
                $display("FAIL enable_outputs cycle %0d: got pwm=%b st=%0d pd=%b want pwm=%b st=%0d pd=%b",
                         k, pwm, state, phase_done, ep, es, epd);
            end
            if (k > 20 && k <= 30) begin
                assertions++;
                if (pwm !== 1'b0) begin
                    failures++;
                    $display("FAIL enable_gap_pwm cycle %0d: got %b want 0", k, pwm);
                end
            end
            if (phase_done === 1'b1 && first_pd < 0) first_pd = k;
        end
        assertions++;
        if (first_pd != 58) begin
            failures++;
            $display("FAIL enable_first_phase_done: got clk %0d want clk 58", first_pd);
        end
    endtask

    task automatic test_random_enable;
        logic e;
        drive_cycle(1'b1, 1'b0, ep, es, epd);
        for (int k = 1; k <= 400; k++) begin
            e = ($urandom % 4) != 0;
            drive_cycle(e, 1'b1, ep, es, epd);
            assertions++;
            if (pwm !== ep || state !== es || phase_done !== epd) begin
                failures++;
                $display("FAIL random_enable cycle %0d en=%b: got pwm=%b st=%0d pd=%b want pwm=%b st=%0d pd=%b",
                         k, e, pwm, state, phase_done, ep, es, epd);
            end
        end
    endtask

    task automatic test_mid_reset;
        int first_pd;
        first_pd = -1;
        drive_cycle(1'b1, 1'b0, ep, es, epd);
        for (int k = 1; k <= 113; k++) drive_cycle(1'b1, 1'b1, ep, es, epd);
        assertions++;
        if (state !== 2'd2 || m_duty(n_en) != 2) begin
            failures++;
            $display("FAIL mid_reset_setup: got state %0d model duty %0d want state 2 duty 2",
                     state, m_duty(n_en));
        end
        drive_cycle(1'b1, 1'b0, ep, es, epd);
        assertions++;
        if (state !== 2'd0 || pwm !== 1'b0 || phase_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abort: got st=%0d pwm=%b pd=%b want st=0 pwm=0 pd=0",
                     state, pwm, phase_done);
        end
        for (int k = 1; k <= 60; k++) begin
            drive_cycle(1'b1, 1'b1, ep, es, epd);
            assertions++;
            if (pwm !== ep || state !== es || phase_done !== epd) begin
                failures++;
                $display("FAIL mid_reset_restart cycle %0d: got pwm=%b st=%0d pd=%b want pwm=%b st=%0d pd=%b",
                         k, pwm, state, phase_done, ep, es, epd);
            end
            if (phase_done === 1'b1 && first_pd < 0) first_pd = k;
        end
        assertions++;
        if (first_pd != 48) begin
            failures++;
            $display("FAIL mid_reset_first_phase_done: got clk %0d want clk 48", first_pd);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        n_en       = 0;
        rst        = 1'b0;
        en         = 1'b0;
        test_reset();
        test_ramp();
        test_phase_seq();
        test_enable();
        test_random_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
